ram_sync: RTL and testbench



---
 rtl/ram_sync_pkg.sv | 10 +
 rtl/ram_sync_if.sv | 25 ++
 rtl/ram_sync_array.sv | 32 +++
 rtl/ram_sync.sv | 88 ++++++++
 tb/tb_ram_sync.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/ram_sync_pkg.sv
// Shared definitions for the synchronous RAM family: FSM state encoding
// reused by other RAM-based blocks.
package ram_sync_pkg;

    typedef logic [0:0] ram_state_t;

    localparam ram_state_t RAM_ST_CLEAR = 1'b0;
    localparam ram_state_t RAM_ST_READY = 1'b1;

endpackage

// File: rtl/ram_sync_if.sv
// Request/ready handshake bus between a core datapath (master) and ram_sync (slave).
interface ram_sync_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8
) ();

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      din;
    logic                  ready;
    logic [WIDTH-1:0]      dout;
    logic                  dout_valid;

    modport master (
        output req, we, addr, din,
        input  ready, dout, dout_valid
    );

    modport slave (
        input  req, we, addr, din,
        output ready, dout, dout_valid
    );

endinterface

// File: rtl/ram_sync_array.sv
// Plain single-write, registered-read storage array with no reset, shaped
// so synthesis maps it onto block RAM.
module ram_sync_array #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_sync.sv
// Synchronous single-port data RAM: clear sweep after reset, then request/ready
// accesses with one-cycle registered reads.
module ram_sync
    import ram_sync_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    ram_sync_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    ram_state_t            r_state;
    ram_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  r_ready;
    logic                  r_dout_valid;
    logic                  r_dout_loaded;

    logic                  w_clearing;
    logic                  w_accept;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_waddr;
    logic [WIDTH-1:0]      w_mem_wdata;
    logic [WIDTH-1:0]      w_rdata;

    // rst_n gating keeps a reset edge from also committing a write.
    assign w_clearing = rst_n && (r_state == RAM_ST_CLEAR);
    assign w_accept   = rst_n && r_ready && bus.req;
    assign w_rd       = w_accept && !bus.we;
    assign w_wr       = w_accept && bus.we;

    assign w_mem_we    = w_clearing || w_wr;
    assign w_mem_waddr = w_clearing ? r_clr_cnt : bus.addr;
    assign w_mem_wdata = w_clearing ? '0 : bus.din;

    always_comb begin
        w_state_nxt = r_state;
        if (w_clearing && (r_clr_cnt == LAST_ADDR)) begin
            w_state_nxt = RAM_ST_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= CLEAR_ON_RESET ? RAM_ST_CLEAR : RAM_ST_READY;
            r_clr_cnt     <= '0;
            r_ready       <= 1'b0;
            r_dout_valid  <= 1'b0;
            r_dout_loaded <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ready      <= (w_state_nxt == RAM_ST_READY);
            r_dout_valid <= w_rd;
            if (w_clearing && (r_clr_cnt != LAST_ADDR)) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
            if (w_rd) begin
                r_dout_loaded <= 1'b1;
            end
        end
    end

    // The array has no reset, so dout reads as zero until the first read lands.
    assign bus.dout       = r_dout_loaded ? w_rdata : '0;
    assign bus.ready      = r_ready;
    assign bus.dout_valid = r_dout_valid;

    ram_sync_array #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_re    (w_rd),
        .i_raddr (bus.addr),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_ram_sync.sv
// Directed plus randomized bench for ram_sync against a word-array reference
// model with a clear-countdown for the post-reset sweep.
module tb_ram_sync;

    localparam int W  = 16;
    localparam int AW = 4;
    localparam int D  = 2 ** AW;

    logic clk;
    logic rst_n;

    ram_sync_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();
    ram_sync_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus_nc ();

    ram_sync #(
        .WIDTH          (W),
        .ADDR_WIDTH     (AW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ram_sync #(
        .WIDTH          (W),
        .ADDR_WIDTH     (AW),
        .CLEAR_ON_RESET (1'b0)
    ) dut_nc (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [W-1:0] m_mem [D];
    logic [W-1:0] m_dout;
    logic         m_valid;
    logic         m_ready;
    int           m_clear_left;
    logic         m_nc_ready;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance reference model, compare outputs.
    task automatic step(input logic rst, input logic rq, input logic w,
                        input logic [AW-1:0] a, input logic [W-1:0] d);
        rst_n    = rst;
        bus.req  = rq;
        bus.we   = w;
        bus.addr = a;
        bus.din  = d;
        @(posedge clk);
        if (!rst) begin
            m_clear_left = D;
            m_ready      = 1'b0;
            m_dout       = '0;
            m_valid      = 1'b0;
            m_nc_ready   = 1'b0;
        end else begin
            m_nc_ready = 1'b1;
            if (m_ready && rq) begin
                if (w) begin
                    m_mem[a] = d;
                    m_valid  = 1'b0;
                end else begin
                    m_dout  = m_mem[a];
                    m_valid = 1'b1;
                end
            end else begin
                m_valid = 1'b0;
            end
            if (m_clear_left > 0) begin
                m_mem[D - m_clear_left] = '0;
                m_clear_left--;
                if (m_clear_left == 0) m_ready = 1'b1;
            end
        end
        #1;
        chk("ready",         {{(W-1){1'b0}}, bus.ready},         {{(W-1){1'b0}}, m_ready});
        chk("dout",          bus.dout,                           m_dout);
        chk("dout_valid",    {{(W-1){1'b0}}, bus.dout_valid},    {{(W-1){1'b0}}, m_valid});
        chk("nc_ready",      {{(W-1){1'b0}}, bus_nc.ready},      {{(W-1){1'b0}}, m_nc_ready});
        chk("nc_dout_valid", {{(W-1){1'b0}}, bus_nc.dout_valid}, '0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.req     = 1'b0;
        bus.we      = 1'b0;
        bus.addr    = '0;
        bus.din     = '0;
        bus_nc.req  = 1'b0;
        bus_nc.we   = 1'b0;
        bus_nc.addr = '0;
        bus_nc.din  = '0;
        m_dout      = '0;
        m_valid     = 1'b0;
        m_ready     = 1'b0;
        m_nc_ready  = 1'b0;
        m_clear_left = D;
        for (int i = 0; i < D; i++) m_mem[i] = 'x;

        // Reset, then the clear sweep with req held high (must be ignored).
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b1, 4'd2, 16'h5555);
        for (int i = 0; i < D + 1; i++) begin
            step(1'b1, 1'b1, i[0], i[AW-1:0], 16'hDEAD);
        end

        // Back-to-back reads of every address: all zero, valid continuous.
        for (int i = 0; i < D; i++) step(1'b1, 1'b1, 1'b0, i[AW-1:0], '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);

        // Write then immediate read-back; valid pulses once.
        step(1'b1, 1'b1, 1'b1, 4'd3, 16'hBEEF);
        step(1'b1, 1'b1, 1'b0, 4'd3, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);

        // dout holds across a later write to the same address.
        step(1'b1, 1'b1, 1'b1, 4'd5, 16'h1234);
        step(1'b1, 1'b1, 1'b0, 4'd5, '0);
        step(1'b1, 1'b1, 1'b1, 4'd5, 16'hFFFF);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b0, 4'd5, '0);

        // Randomized mix of reads, writes and idle cycles.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, D - 1)), W'($urandom));
        end

        // Reset in the middle of a read and again at clear-cycle 7.
        step(1'b1, 1'b1, 1'b1, 4'd0, 16'hAAAA);
        step(1'b1, 1'b1, 1'b0, 4'd0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 4'd0, '0);
        for (int i = 0; i < D + 1; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b0, 4'd0, '0);
        chk("addr0_after_clear", bus.dout, 16'h0000);
        step(1'b1, 1'b0, 1'b0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
